kf_meas_prep: RTL and testbench

//   Measurement front-end feeding the 2D Kalman angle filter application.

---
 rtl/kf_meas_prep_if.sv | 22 ++
 rtl/kf_meas_prep.sv | 149 ++++++++++++++
 tb/tb_kf_meas_prep.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/kf_meas_prep_if.sv
// Sample-in / measurement-out bus of the Kalman measurement front-end.
// master = sample producer and result consumer; slave = kf_meas_prep.
interface kf_meas_prep_if #(
  parameter int W     = 24,
  parameter int RAW_W = 16
);
  logic [RAW_W-1:0] raw_in;
  logic             raw_valid;
  logic [W-1:0]     meas_out;
  logic             meas_valid;
  logic             meas_ack;

  modport master (
    output raw_in, raw_valid, meas_ack,
    input  meas_out, meas_valid
  );

  modport slave (
    input  raw_in, raw_valid, meas_ack,
    output meas_out, meas_valid
  );
endinterface

// File: rtl/kf_meas_prep.sv
// Block-averages 2**AVG_LOG2 raw samples into a held sign-magnitude word; last sample -> meas_valid in 2 edges.
// No stall on the sample side: an unacked word is overwritten and counted in drop_cnt.
module kf_meas_prep #(
  parameter int W        = 24,
  parameter int FRAC     = 14,
  parameter int RAW_W    = 16,
  parameter int RAW_FRAC = 12,
  parameter int AVG_LOG2 = 2,
  parameter int DROP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  kf_meas_prep_if.slave     m,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  localparam int AW = RAW_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int XW = RAW_W + 1;
  localparam int SH = FRAC - RAW_FRAC;
  localparam int MW = (XW + SH > W) ? XW + SH : W;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << AVG_LOG2) - 1);
  localparam logic [MW-1:0] MAG_MAX  = MW'((64'd1 << (W - 1)) - 64'd1);

  typedef enum logic [1:0] {IDLE, ACCUM, CONV} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   last;

  logic signed [AW-1:0] acc;
  logic        [CW-1:0] cnt;
  logic signed [AW-1:0] raw_x;
  logic signed [AW-1:0] avg_full;
  logic signed [XW-1:0] avg_x;
  logic        [XW-1:0] abs_v;
  logic        [MW-1:0] mag_ext;
  logic        [W-2:0]  mag_w;
  logic        [W-1:0]  conv_word;

  logic         res_vld;
  logic [W-1:0] res_q;
  logic [W-1:0] meas_q;
  logic         meas_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = ACCUM;
      ACCUM:   if (!enable) state_nxt = IDLE;
               else if (last) state_nxt = CONV;
      CONV:    if (!enable) state_nxt = IDLE;
               else if (last) state_nxt = CONV;
               else state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
  end

  // A sample in the CONV cycle opens the next block; with 1-sample blocks it also closes it.
  always_comb begin
    busy   = (state != IDLE);
    accept = 1'b0;
    last   = 1'b0;
    case (state)
      ACCUM: begin
        accept = enable && m.raw_valid;
        last   = accept && (cnt == LAST_CNT);
      end
      CONV: begin
        accept = enable && m.raw_valid;
        last   = accept && (AVG_LOG2 == 0);
      end
      default: ;
    endcase
  end

  assign raw_x = AW'($signed(m.raw_in));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (!enable) begin
            acc <= '0;
            cnt <= '0;
          end else if (accept) begin
            acc <= acc + raw_x;
            cnt <= cnt + 1'b1;
          end
        end
        CONV: begin
          acc <= accept ? raw_x : '0;
          cnt <= accept ? CW'(1) : '0;
        end
        default: begin
          acc <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

  // The block mean always fits RAW_W bits; the extra bit keeps |-2**(RAW_W-1)| representable.
  assign avg_full  = acc >>> AVG_LOG2;
  assign avg_x     = XW'(avg_full);
  assign abs_v     = avg_x[XW-1] ? XW'(-avg_x) : XW'(avg_x);
  assign mag_ext   = MW'(abs_v) << SH;
  assign mag_w     = (mag_ext > MAG_MAX) ? '1 : mag_ext[W-2:0];
  assign conv_word = {avg_x[XW-1], mag_w};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld <= 1'b0;
      res_q   <= '0;
    end else begin
      res_vld <= (state == CONV);
      res_q   <= conv_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_q     <= '0;
      meas_vld_q <= 1'b0;
      drop_cnt   <= '0;
    end else if (res_vld) begin
      meas_q     <= res_q;
      meas_vld_q <= 1'b1;
      if (meas_vld_q && !m.meas_ack && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end else if (m.meas_ack && meas_vld_q) begin
      meas_vld_q <= 1'b0;
    end
  end

  assign m.meas_out   = meas_q;
  assign m.meas_valid = meas_vld_q;

endmodule

// File: tb/tb_kf_meas_prep.sv
// Directed bench for kf_meas_prep with default parameters (4-sample blocks).
module tb_kf_meas_prep;
  localparam int W      = 24;
  localparam int RAW_W  = 16;
  localparam int DROP_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [DROP_W-1:0] drop_cnt;
  logic              busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  kf_meas_prep_if #(.W(W), .RAW_W(RAW_W)) bus ();

  kf_meas_prep dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .m        (bus),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    bus.raw_in    = RAW_W'(v);
    bus.raw_valid = 1'b1;
    tick();
    bus.raw_valid = 1'b0;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic ack();
    bus.meas_ack = 1'b1;
    tick();
    bus.meas_ack = 1'b0;
  endtask

  // Full block, wait out the 2-edge latency, check the word, then consume it.
  task automatic block_word(input string tag, input int a, input int b, input int c, input int d,
                            input logic [31:0] exp);
    send4(a, b, c, d);
    tick();
    tick();
    check({tag, "_out"}, 32'(bus.meas_out), exp);
    check({tag, "_vld"}, 32'(bus.meas_valid), 32'd1);
    ack();
    check({tag, "_acked"}, 32'(bus.meas_valid), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    enable        = 1'b0;
    bus.raw_in    = '0;
    bus.raw_valid = 1'b0;
    bus.meas_ack  = 1'b0;
    #12;
    check("rst_out", 32'(bus.meas_out), 32'h0);
    check("rst_vld", 32'(bus.meas_valid), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    enable = 1'b1;
    tick();
    check("busy_run", 32'(busy), 32'd1);

    // 1.0 in Q.12 -> 1.0 in Q.14, with exact latency
    send4(4096, 4096, 4096, 4096);
    check("t1_lat_k", 32'(bus.meas_valid), 32'd0);
    tick();
    check("t1_lat_k1", 32'(bus.meas_valid), 32'd0);
    tick();
    check("t1_lat_k2", 32'(bus.meas_valid), 32'd1);
    check("t1_out", 32'(bus.meas_out), 32'h004000);
    ack();
    check("t1_acked", 32'(bus.meas_valid), 32'd0);

    block_word("t2_neg", -2048, -2048, -2048, -2048, 32'h802000);
    block_word("t2_pos", 1, 2, 3, 4, 32'h000008);
    block_word("t2_floor", -1, -1, -1, -2, 32'h800008);
    block_word("t3_zero", 1, -1, 2, -2, 32'h000000);
    block_word("t3_min", -32768, -32768, -32768, -32768, 32'h820000);

    // Overwrite without ack
    send4(4096, 4096, 4096, 4096);
    tick();
    tick();
    send4(100, 100, 100, 100);
    tick();
    tick();
    check("t4_ovr_out", 32'(bus.meas_out), 32'h000190);
    check("t4_ovr_vld", 32'(bus.meas_valid), 32'd1);
    check("t4_ovr_drop", 32'(drop_cnt), 32'd1);
    // Ack lands on the same edge as the next load: no drop
    send4(1, 2, 3, 4);
    tick();
    bus.meas_ack = 1'b1;
    tick();
    bus.meas_ack = 1'b0;
    check("t4_coin_out", 32'(bus.meas_out), 32'h000008);
    check("t4_coin_vld", 32'(bus.meas_valid), 32'd1);
    check("t4_coin_drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 300; i++) begin
      send4(4096, 4096, 4096, 4096);
      tick();
      tick();
    end
    check("t4_sat_drop", 32'(drop_cnt), 32'd255);
    check("t4_sat_vld", 32'(bus.meas_valid), 32'd1);
    ack();
    check("t4_sat_acked", 32'(bus.meas_valid), 32'd0);
    ack();
    check("t4_idle_ack_vld", 32'(bus.meas_valid), 32'd0);
    check("t4_idle_ack_drop", 32'(drop_cnt), 32'd255);

    // Partial block abandoned on enable drop
    send(1000);
    send(1000);
    enable = 1'b0;
    tick();
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_drop", 32'(drop_cnt), 32'd255);
    enable = 1'b1;
    tick();
    block_word("t5_fresh", 100, 100, 100, 100, 32'h000190);

    // Async reset mid-block with a word pending
    send4(4096, 4096, 4096, 4096);
    tick();
    tick();
    check("t6_pend_vld", 32'(bus.meas_valid), 32'd1);
    send(500);
    send(500);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_out", 32'(bus.meas_out), 32'h0);
    check("t6_rst_vld", 32'(bus.meas_valid), 32'd0);
    check("t6_rst_drop", 32'(drop_cnt), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    block_word("t6_after", 1, 2, 3, 4, 32'h000008);
    check("t6_after_drop", 32'(drop_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
